// File: rtl/hist_eq_sched_if.sv
// Bundle of the scheduler's control, calculator-RAM, histogram-RAM and LUT-RAM signals.
// The scheduler connects through the slave modport; its environment uses master.
interface hist_eq_sched_if #(
    parameter int BIN_W = 14,
    parameter int CNT_W = 18,
    parameter int CDF_W = 20,
    parameter int LUT_W = 8
);
    logic             enable;
    logic [7:0]       period;
    logic [23:0]      scale;
    logic             frame_start;
    logic             hist_upd;
    logic             hist_rdy;
    logic             calc_ram_we;
    logic [BIN_W-1:0] calc_ram_addr;
    logic [CNT_W-1:0] calc_ram_din;
    logic [CNT_W-1:0] calc_ram_dout;
    logic             ram_we;
    logic [BIN_W-1:0] ram_addr;
    logic [CNT_W-1:0] ram_din;
    logic [CNT_W-1:0] ram_dout;
    logic             lut_we;
    logic [BIN_W-1:0] lut_addr;
    logic [LUT_W-1:0] lut_din;
    logic             busy;
    logic             lut_done;
    logic [CDF_W-1:0] total_cnt;

    modport slave (
        input  enable, period, scale, frame_start, hist_rdy,
        input  calc_ram_we, calc_ram_addr, calc_ram_din, ram_dout,
        output hist_upd, calc_ram_dout, ram_we, ram_addr, ram_din,
        output lut_we, lut_addr, lut_din, busy, lut_done, total_cnt
    );

    modport master (
        output enable, period, scale, frame_start, hist_rdy,
        output calc_ram_we, calc_ram_addr, calc_ram_din, ram_dout,
        input  hist_upd, calc_ram_dout, ram_we, ram_addr, ram_din,
        input  lut_we, lut_addr, lut_din, busy, lut_done, total_cnt
    );
endinterface

// File: rtl/hist_eq_sched.sv
// Histogram refresh scheduler: requests a new histogram every PERIOD frames, then
// borrows the histogram RAM to accumulate the CDF and write the scaled equalization LUT.
//
// state       | meaning
// IDLE        | scheduling disabled
// WAIT_FRAMES | counting frame_start pulses up to max(period,1)
// REQ         | hist_upd held until the calculator drops hist_rdy
// WAIT_CALC   | calculator busy; wait for hist_rdy
// SCAN        | read every bin once, one address per cycle
// FLUSH       | drain the 3-stage CDF/LUT pipeline
// DONE        | publish total_cnt, pulse lut_done
module hist_eq_sched #(
    parameter int BIN_W = 14,
    parameter int CNT_W = 18,
    parameter int CDF_W = 20,
    parameter int LUT_W = 8
) (
    input logic clk,
    input logic srst,
    hist_eq_sched_if.slave bus
);
    localparam int SCALE_W = 24;
    localparam int PROD_W  = CDF_W + SCALE_W;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WAIT_FRAMES = 3'd1;
    localparam logic [2:0] S_REQ         = 3'd2;
    localparam logic [2:0] S_WAIT_CALC   = 3'd3;
    localparam logic [2:0] S_SCAN        = 3'd4;
    localparam logic [2:0] S_FLUSH       = 3'd5;
    localparam logic [2:0] S_DONE        = 3'd6;

    localparam logic [BIN_W-1:0] LAST_ADDR = '1;
    localparam logic [CDF_W-1:0] CDF_MAX   = '1;

    logic [2:0]       state;
    logic [7:0]       frame_cnt;
    logic [BIN_W-1:0] scan_addr;
    logic [1:0]       flush_cnt;
    logic             hist_upd_q;
    logic             lut_done_q;
    logic [CDF_W-1:0] total_cnt_q;
    logic [CDF_W-1:0] cdf;
    logic             vld_s1;
    logic             vld_s2;
    logic [BIN_W-1:0] addr_s1;
    logic [BIN_W-1:0] addr_s2;
    logic             lut_we_q;
    logic [BIN_W-1:0] lut_addr_q;
    logic [LUT_W-1:0] lut_din_q;

    logic             scan_own;
    logic [CDF_W:0]   cdf_sum;
    logic [CDF_W-1:0] cdf_next;
    logic [PROD_W-1:0] prod;
    logic [CDF_W-1:0] prod_int;
    logic [SCALE_W-1:0] prod_frac_unused;
    logic [LUT_W-1:0] lut_val;
    logic [7:0]       eff_period;
    logic [8:0]       frame_next;
    logic             frames_reached;

    assign scan_own = (state == S_SCAN) || (state == S_FLUSH);

    always_comb begin
        bus.ram_we   = bus.calc_ram_we;
        bus.ram_addr = bus.calc_ram_addr;
        bus.ram_din  = bus.calc_ram_din;
        if (scan_own) begin
            bus.ram_we   = 1'b0;
            bus.ram_addr = scan_addr;
            bus.ram_din  = '0;
        end
    end

    assign bus.calc_ram_dout = bus.ram_dout;

    // Saturating CDF accumulate, then Q0.24 gain with the integer part clamped to the LUT range.
    assign cdf_sum  = {1'b0, cdf} + {{(CDF_W + 1 - CNT_W){1'b0}}, bus.ram_dout};
    assign cdf_next = cdf_sum[CDF_W] ? CDF_MAX : cdf_sum[CDF_W-1:0];
    assign prod     = {{SCALE_W{1'b0}}, cdf} * {{CDF_W{1'b0}}, bus.scale};
    assign {prod_int, prod_frac_unused} = prod;
    assign lut_val  = (|prod_int[CDF_W-1:LUT_W]) ? {LUT_W{1'b1}} : prod_int[LUT_W-1:0];

    assign eff_period     = (bus.period == 8'd0) ? 8'd1 : bus.period;
    assign frame_next     = {1'b0, frame_cnt} + 9'd1;
    assign frames_reached = frame_next >= {1'b0, eff_period};

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state       <= S_IDLE;
            frame_cnt   <= '0;
            scan_addr   <= '0;
            flush_cnt   <= '0;
            hist_upd_q  <= 1'b0;
            lut_done_q  <= 1'b0;
            total_cnt_q <= '0;
            cdf         <= '0;
            vld_s1      <= 1'b0;
            vld_s2      <= 1'b0;
            addr_s1     <= '0;
            addr_s2     <= '0;
            lut_we_q    <= 1'b0;
            lut_addr_q  <= '0;
            lut_din_q   <= '0;
        end else begin
            vld_s1     <= (state == S_SCAN);
            addr_s1    <= scan_addr;
            vld_s2     <= vld_s1;
            addr_s2    <= addr_s1;
            lut_we_q   <= vld_s2;
            lut_addr_q <= addr_s2;
            lut_din_q  <= lut_val;
            lut_done_q <= (state == S_DONE);
            if (vld_s1) begin
                cdf <= cdf_next;
            end

            case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        state     <= S_WAIT_FRAMES;
                        frame_cnt <= '0;
                    end
                end
                S_WAIT_FRAMES: begin
                    if (!bus.enable) begin
                        state <= S_IDLE;
                    end else if (bus.frame_start) begin
                        if (frames_reached) begin
                            state      <= S_REQ;
                            frame_cnt  <= '0;
                            hist_upd_q <= 1'b1;
                        end else begin
                            frame_cnt <= frame_next[7:0];
                        end
                    end
                end
                S_REQ: begin
                    if (!bus.hist_rdy) begin
                        hist_upd_q <= 1'b0;
                        state      <= S_WAIT_CALC;
                    end
                end
                S_WAIT_CALC: begin
                    if (bus.hist_rdy) begin
                        state     <= S_SCAN;
                        scan_addr <= '0;
                        cdf       <= '0;
                    end
                end
                S_SCAN: begin
                    if (scan_addr == LAST_ADDR) begin
                        state     <= S_FLUSH;
                        flush_cnt <= '0;
                    end else begin
                        scan_addr <= scan_addr + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == 2'd2) begin
                        state <= S_DONE;
                    end else begin
                        flush_cnt <= flush_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    total_cnt_q <= cdf;
                    if (bus.enable) begin
                        state     <= S_WAIT_FRAMES;
                        frame_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.hist_upd  = hist_upd_q;
    assign bus.lut_we    = lut_we_q;
    assign bus.lut_addr  = lut_addr_q;
    assign bus.lut_din   = lut_din_q;
    assign bus.lut_done  = lut_done_q;
    assign bus.total_cnt = total_cnt_q;
    assign bus.busy      = (state != S_IDLE) && (state != S_WAIT_FRAMES);
endmodule

// File: tb/tb_hist_eq_sched.sv
// Bench for hist_eq_sched: acts as calculator, histogram RAM and frame source, and
// checks every LUT write against a CDF/gain model computed from the histogram contents.
module tb_hist_eq_sched;
    localparam int NB      = 16384;
    localparam longint CDF_MAX = 64'd1048575;

    logic clk;
    logic srst;
    hist_eq_sched_if #(.BIN_W(14), .CNT_W(18), .CDF_W(20), .LUT_W(8)) bus ();

    hist_eq_sched #(.BIN_W(14), .CNT_W(18), .CDF_W(20), .LUT_W(8)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    logic [17:0] mem  [NB];
    logic [17:0] hist [NB];
    int          exp_lut [NB];
    int          act_lut [NB];
    longint      exp_total;
    logic        load_req;

    int vectors;
    int miscompares;
    int cyc;
    int scan_start;
    bit scan_active;
    int k_cmp;
    bit exp_we;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Histogram RAM with one-cycle read latency; load_req bulk-loads it from hist.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < NB; i++) mem[i] <= hist[i];
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic compute_exp(input longint sc);
        longint c;
        longint v;
        c = 0;
        for (int a = 0; a < NB; a++) begin
            c = c + longint'(hist[a]);
            if (c > CDF_MAX) c = CDF_MAX;
            v = (c * sc) >> 24;
            exp_lut[a] = (v > 255) ? 255 : int'(v);
        end
        exp_total = c;
    endtask

    task automatic load_hist();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic start_scan(input int nwr);
        bit ok;
        int a;
        int v;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.hist_upd) ok = 1'b1;
            else tick();
        end
        chk("upd_seen", longint'(ok), 64'd1);
        bus.hist_rdy = 1'b0;
        tick();
        chk("upd_fall", longint'(bus.hist_upd), 64'd0);
        chk("busy_calc", longint'(bus.busy), 64'd1);
        for (int i = 0; i < nwr; i++) begin
            a = int'($urandom_range(0, NB - 1));
            v = int'($urandom_range(0, 5000));
            bus.calc_ram_we   = 1'b1;
            bus.calc_ram_addr = 14'(a);
            bus.calc_ram_din  = 18'(v);
            hist[a] = 18'(v);
            tick();
        end
        bus.calc_ram_we = 1'b0;
        compute_exp(longint'(bus.scale));
        bus.hist_rdy = 1'b1;
        scan_start   = cyc + 1;
        scan_active  = 1'b1;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 17000 && !ok; i++) begin
            tick();
            if (bus.lut_done) ok = 1'b1;
        end
        chk("done_seen", longint'(ok), 64'd1);
        chk("done_latency", longint'(cyc - scan_start + 1), 64'd16389);
        chk("total_cnt", longint'(bus.total_cnt), exp_total);
        tick();
        scan_active = 1'b0;
    endtask

    // Per-cycle comparison against the scan timeline and the model LUT.
    always @(negedge clk) begin
        if (!srst) begin
            chk("dout_track", longint'(bus.calc_ram_dout), longint'(bus.ram_dout));
            if (scan_active) begin
                k_cmp = cyc - scan_start;
                if (k_cmp >= 0 && k_cmp < NB) begin
                    chk("scan_addr", longint'(bus.ram_addr), longint'(k_cmp));
                    chk("scan_we", longint'(bus.ram_we), 64'd0);
                end
                exp_we = (k_cmp >= 3) && (k_cmp < NB + 3);
                chk("lut_we", longint'(bus.lut_we), longint'(exp_we));
                if (exp_we && bus.lut_we) begin
                    chk("lut_addr", longint'(bus.lut_addr), longint'(k_cmp - 3));
                    chk("lut_din", longint'(bus.lut_din), longint'(exp_lut[k_cmp - 3]));
                    act_lut[k_cmp - 3] = int'(bus.lut_din);
                end
                chk("lut_done", longint'(bus.lut_done), longint'(k_cmp == NB + 4));
                if (k_cmp >= 0) chk("busy_scan", longint'(bus.busy), longint'(k_cmp < NB + 4));
            end else begin
                chk("idle_lut_we", longint'(bus.lut_we), 64'd0);
                chk("idle_lut_done", longint'(bus.lut_done), 64'd0);
                chk("mux_we", longint'(bus.ram_we), longint'(bus.calc_ram_we));
                chk("mux_addr", longint'(bus.ram_addr), longint'(bus.calc_ram_addr));
                chk("mux_din", longint'(bus.ram_din), longint'(bus.calc_ram_din));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit mono;
        int per;
        int sent;
        bit fs;
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        scan_start    = 0;
        scan_active   = 1'b0;
        load_req      = 1'b0;
        srst          = 1'b1;
        bus.enable    = 1'b0;
        bus.period    = 8'd3;
        bus.scale     = 24'd0;
        bus.frame_start   = 1'b0;
        bus.hist_rdy      = 1'b1;
        bus.calc_ram_we   = 1'b0;
        bus.calc_ram_addr = '0;
        bus.calc_ram_din  = '0;
        for (int i = 0; i < NB; i++) hist[i] = '0;
        load_hist();
        tick();
        tick();
        chk("rst_hist_upd", longint'(bus.hist_upd), 64'd0);
        chk("rst_lut_we", longint'(bus.lut_we), 64'd0);
        chk("rst_busy", longint'(bus.busy), 64'd0);
        chk("rst_lut_done", longint'(bus.lut_done), 64'd0);
        chk("rst_total", longint'(bus.total_cnt), 64'd0);
        srst = 1'b0;
        tick();

        // Calculator owns the RAM while idle.
        bus.calc_ram_we   = 1'b1;
        bus.calc_ram_addr = 14'h1234;
        bus.calc_ram_din  = 18'd7;
        #1;
        chk("calc_we_pass", longint'(bus.ram_we), 64'd1);
        chk("calc_addr_pass", longint'(bus.ram_addr), 64'h1234);
        chk("calc_din_pass", longint'(bus.ram_din), 64'd7);
        tick();
        bus.calc_ram_we = 1'b0;
        tick();
        chk("calc_readback", longint'(bus.calc_ram_dout), 64'd7);

        // Two-bin histogram; gain rounded up from 255*2^24/2000 so the full CDF maps to 255.
        for (int i = 0; i < NB; i++) hist[i] = '0;
        hist[0]      = 18'd1000;
        hist[NB - 1] = 18'd1000;
        load_hist();
        bus.scale = 24'd2139096;
        compute_exp(64'd2139096);
        chk("model_lut0", longint'(exp_lut[0]), 64'd127);
        chk("model_lut16382", longint'(exp_lut[NB - 2]), 64'd127);
        chk("model_lut16383", longint'(exp_lut[NB - 1]), 64'd255);
        chk("model_total", exp_total, 64'd2000);
        bus.period = 8'd3;
        bus.enable = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            chk("p3_upd", longint'(bus.hist_upd), longint'(p == 2));
            if (p < 2) tick();
        end
        start_scan(0);
        wait_done();
        chk("t1_lut0", longint'(act_lut[0]), 64'd127);
        chk("t1_lut16382", longint'(act_lut[NB - 2]), 64'd127);
        chk("t1_lut16383", longint'(act_lut[NB - 1]), 64'd255);
        chk("t1_total", longint'(bus.total_cnt), 64'd2000);

        // Every bin at full scale: CDF must clamp, never wrap.
        for (int i = 0; i < NB; i++) hist[i] = 18'h3FFFF;
        load_hist();
        bus.scale = 24'hFFFFFF;
        compute_exp(64'hFFFFFF);
        chk("model_sat_total", exp_total, 64'd1048575);
        bus.period = 8'd0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("period0_upd", longint'(bus.hist_upd), 64'd1);
        start_scan(0);
        wait_done();
        chk("sat_total", longint'(bus.total_cnt), 64'd1048575);
        mono = 1'b1;
        for (int i = 1; i < NB; i++) if (act_lut[i] < act_lut[i - 1]) mono = 1'b0;
        chk("sat_monotonic", longint'(mono), 64'd1);

        // Random histogram, random period/frame spacing, random gain, calc writes in flight.
        for (int i = 0; i < NB; i++) hist[i] = 18'($urandom_range(0, 60));
        load_hist();
        per = int'($urandom_range(1, 4));
        bus.period = 8'(per);
        bus.scale  = 24'($urandom_range(1, 12000));
        sent = 0;
        for (int i = 0; i < 200 && sent < per; i++) begin
            fs = 1'($urandom_range(0, 1));
            bus.frame_start = fs;
            tick();
            bus.frame_start = 1'b0;
            if (fs) sent++;
            chk("rand_upd", longint'(bus.hist_upd), longint'(sent == per));
        end
        start_scan(40);
        wait_done();

        // A frame_start coinciding with enable falling is dropped.
        bus.period = 8'd2;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("en_upd_a", longint'(bus.hist_upd), 64'd0);
        bus.enable = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("en_fall_upd", longint'(bus.hist_upd), 64'd0);
        chk("en_fall_busy", longint'(bus.busy), 64'd0);
        bus.enable = 1'b1;
        tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("en_upd_b", longint'(bus.hist_upd), 64'd0);
        tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("en_upd_c", longint'(bus.hist_upd), 64'd1);

        // Reset in the middle of a scan.
        start_scan(0);
        for (int i = 0; i < 200 && cyc < scan_start + 100; i++) tick();
        chk("rst_scan_addr", longint'(bus.ram_addr), 64'd100);
        srst = 1'b1;
        scan_active = 1'b0;
        #1;
        chk("midrst_lut_we", longint'(bus.lut_we), 64'd0);
        chk("midrst_busy", longint'(bus.busy), 64'd0);
        chk("midrst_total", longint'(bus.total_cnt), 64'd0);
        chk("midrst_upd", longint'(bus.hist_upd), 64'd0);
        bus.enable = 1'b0;
        tick();
        tick();
        srst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("post_rst_busy", longint'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
